// File: rtl/fu_seq_pkg.sv
// Shared types and helpers for the fu_seq run-sequencer.
package fu_seq_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Adds a and b, clamping the result at max.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[63:0];
  endfunction

endpackage

// File: rtl/fu_seq_cnt.sv
// Up-counter with synchronous clear/load/enable; tc flags that the enabled increment reaches limit.
module fu_seq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (load)  count <= load_val;
    else if (en)    count <= count + W'(1);
  end

  assign tc = en && ((count + W'(1)) == limit);

endmodule

// File: rtl/fu_seq.sv
// Run-sequencer driving FU init/disable nets: INIT -> RUN -> DRAIN -> DONE.
// Optional stall-cycle counter output enabled by FU_SEQ_STALL_CNT_EN.
module fu_seq
  import fu_seq_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned INIT_CYC  = 1,
  parameter int unsigned DRAIN_LAT = 4
) (
  input  logic             fu_seq_clk,
  input  logic             fu_seq_reset,
  input  logic             fu_seq_start,
  input  logic [CNT_W-1:0] fu_seq_iter,
  input  logic             fu_seq_stall,
  input  logic             fu_seq_abort,
  output logic             fu_seq_fu_init,
  output logic             fu_seq_fu_disable,
  output logic             fu_seq_busy,
  output logic             fu_seq_done,
  output logic [CNT_W-1:0] fu_seq_iter_cnt
`ifdef FU_SEQ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] fu_seq_stall_cnt
`endif
);

  localparam int unsigned DRAIN_W   = (DRAIN_LAT < 2) ? 1 : $clog2(DRAIN_LAT + 1);
  localparam state_t      AFTER_RUN = (DRAIN_LAT != 0) ? DRAIN : DONE;

  state_t             state, nxt;
  logic [CNT_W-1:0]   iter_q;
  logic               init_q, busy_q, done_q, gate_q;
  logic               accept;
  logic               init_en, iter_en, drain_en;
  logic               init_tc, iter_tc, drain_tc;
  logic [3:0]         init_count;
  logic [DRAIN_W-1:0] drain_count;
  logic               unused_counts;

  assign accept   = (state == IDLE) && fu_seq_start && !fu_seq_abort;
  assign init_en  = (state == INIT) && !fu_seq_abort;
  assign iter_en  = (state == RUN) && !fu_seq_stall && !fu_seq_abort;
  assign drain_en = (state == DRAIN) && !fu_seq_stall && !fu_seq_abort;

  fu_seq_cnt #(.W(4)) u_init_cnt (
    .clk      (fu_seq_clk),
    .reset    (fu_seq_reset),
    .clear    (accept),
    .load     (1'b0),
    .load_val ('0),
    .en       (init_en),
    .limit    (4'(INIT_CYC)),
    .count    (init_count),
    .tc       (init_tc)
  );

  fu_seq_cnt #(.W(CNT_W)) u_iter_cnt (
    .clk      (fu_seq_clk),
    .reset    (fu_seq_reset),
    .clear    (accept),
    .load     (1'b0),
    .load_val ('0),
    .en       (iter_en),
    .limit    (iter_q),
    .count    (fu_seq_iter_cnt),
    .tc       (iter_tc)
  );

  fu_seq_cnt #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (fu_seq_clk),
    .reset    (fu_seq_reset),
    .clear    (accept),
    .load     (1'b0),
    .load_val ('0),
    .en       (drain_en),
    .limit    (DRAIN_W'(DRAIN_LAT)),
    .count    (drain_count),
    .tc       (drain_tc)
  );

  assign unused_counts = ^{init_count, drain_count};

  always_comb begin
    nxt = state;
    if (fu_seq_abort) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (fu_seq_start) nxt = INIT;
        INIT:    if (init_tc) nxt = (iter_q != '0) ? RUN : AFTER_RUN;
        RUN:     if (iter_tc) nxt = AFTER_RUN;
        DRAIN:   if (drain_tc) nxt = DONE;
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge fu_seq_clk) begin
    if (fu_seq_reset) begin
      state  <= IDLE;
      iter_q <= '0;
      init_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      state  <= nxt;
      if (accept) iter_q <= fu_seq_iter;
      init_q <= (nxt == INIT);
      busy_q <= (nxt != IDLE);
      done_q <= (nxt == DONE);
      gate_q <= (nxt == RUN) || (nxt == DRAIN);
    end
  end

  assign fu_seq_fu_init    = init_q;
  assign fu_seq_busy       = busy_q;
  assign fu_seq_done       = done_q;
  // In RUN/DRAIN the stall input freezes the FUs without a cycle of delay.
  assign fu_seq_fu_disable = gate_q ? fu_seq_stall : 1'b1;

`ifdef FU_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge fu_seq_clk) begin
    if (fu_seq_reset) begin
      stall_cnt_q <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
    end else if (gate_q && fu_seq_stall && !fu_seq_abort) begin
      stall_cnt_q <= CNT_W'(sat_add(64'(stall_cnt_q), 64'd1, 64'({CNT_W{1'b1}})));
    end
  end

  assign fu_seq_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fu_seq.sv
// Self-checking bench for fu_seq: directed scenarios with literal expectations plus a random run against a phase model.
module tb_fu_seq;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned INIT_CYC  = 1;
  localparam int unsigned DRAIN_LAT = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_INIT  = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_DRAIN = 3;
  localparam int PH_DONE  = 4;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] iter  = '0;
  logic             fu_init, fu_disable, busy, done;
  logic [CNT_W-1:0] iter_cnt;
`ifdef FU_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fu_seq #(
    .CNT_W     (CNT_W),
    .INIT_CYC  (INIT_CYC),
    .DRAIN_LAT (DRAIN_LAT)
  ) dut (
    .fu_seq_clk        (clk),
    .fu_seq_reset      (rst),
    .fu_seq_start      (start),
    .fu_seq_iter       (iter),
    .fu_seq_stall      (stall),
    .fu_seq_abort      (abort),
    .fu_seq_fu_init    (fu_init),
    .fu_seq_fu_disable (fu_disable),
    .fu_seq_busy       (busy),
    .fu_seq_done       (done),
    .fu_seq_iter_cnt   (iter_cnt)
`ifdef FU_SEQ_STALL_CNT_EN
    ,
    .fu_seq_stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus remaining-cycle budgets, advanced once per rising edge.
  int ph = PH_IDLE;
  int left = 0;
  int tgt = 0;
  int cnt = 0;
  longint scnt = 0;
  bit model_valid = 1'b0;
  localparam longint SAT_MAX = (64'd1 << CNT_W) - 1;

  task automatic model_step();
    if (rst) begin
      ph = PH_IDLE; cnt = 0; scnt = 0; left = 0; model_valid = 1'b1;
    end else if (abort) begin
      ph = PH_IDLE;
    end else begin
      case (ph)
        PH_IDLE: if (start) begin
          tgt = int'(iter); cnt = 0; scnt = 0; left = int'(INIT_CYC); ph = PH_INIT;
        end
        PH_INIT: begin
          left = left - 1;
          if (left == 0) begin
            if (tgt != 0) ph = PH_RUN;
            else if (DRAIN_LAT != 0) begin ph = PH_DRAIN; left = int'(DRAIN_LAT); end
            else ph = PH_DONE;
          end
        end
        PH_RUN: if (stall) begin
          if (scnt < SAT_MAX) scnt = scnt + 1;
        end else begin
          cnt = cnt + 1;
          if (cnt == tgt) begin
            if (DRAIN_LAT != 0) begin ph = PH_DRAIN; left = int'(DRAIN_LAT); end
            else ph = PH_DONE;
          end
        end
        PH_DRAIN: if (stall) begin
          if (scnt < SAT_MAX) scnt = scnt + 1;
        end else begin
          left = left - 1;
          if (left == 0) ph = PH_DONE;
        end
        default: ph = PH_IDLE;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      check("fu_init", 32'(fu_init), 32'(ph == PH_INIT));
      check("fu_disable", 32'(fu_disable),
            32'((ph == PH_RUN || ph == PH_DRAIN) ? stall : 1'b1));
      check("busy", 32'(busy), 32'(ph != PH_IDLE));
      check("done", 32'(done), 32'(ph == PH_DONE));
      check("iter_cnt", 32'(iter_cnt), 32'(cnt));
`ifdef FU_SEQ_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(scnt));
`endif
    end
  end

  // Cycle k=0 presents the start; runs exactly ncyc cycles, recording done pulses.
  task automatic run_seq(input int it, input int st_from, input int st_len, input int ab_at,
                         input int s1, input int s2, input int s3, input int ncyc,
                         output int nd, output int lat_first, output int lat_last,
                         output int busy_after);
    nd = 0; lat_first = -1; lat_last = -1; busy_after = -1;
    for (int k = 0; k < ncyc; k++) begin
      iter  = CNT_W'(it);
      start = (k == 0) || (k == s1) || (k == s2) || (k == s3);
      stall = (k >= st_from) && (k < st_from + st_len);
      abort = (k == ab_at);
      @(negedge clk);
      if (done) begin
        nd++;
        if (lat_first < 0) lat_first = k;
        lat_last = k;
      end
      if (lat_first >= 0 && k == lat_first + 1) busy_after = int'(busy);
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0; abort = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd, lf, ll, ba;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_disable", 32'(fu_disable), 32'd1);
    check("rst_init", 32'(fu_init), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_iter_cnt", 32'(iter_cnt), 32'd0);
    @(posedge clk); #1;

    // iter = 3, no stall
    run_seq(3, -1, 0, -1, -1, -1, -1, 12, nd, lf, ll, ba);
    check("i3_ndone", 32'(nd), 32'd1);
    check("i3_done_lat", 32'(lf), 32'd9);
    check("i3_busy_after", 32'(ba), 32'd0);
    check("i3_iter_cnt", 32'(iter_cnt), 32'd3);

    // starts while busy and in DONE ignored, start right after DONE accepted
    run_seq(3, -1, 0, -1, 4, 9, 10, 22, nd, lf, ll, ba);
    check("rs_ndone", 32'(nd), 32'd2);
    check("rs_first", 32'(lf), 32'd9);
    check("rs_last", 32'(ll), 32'd19);

    // iter = 0 goes straight to drain
    run_seq(0, -1, 0, -1, -1, -1, -1, 10, nd, lf, ll, ba);
    check("i0_done_lat", 32'(lf), 32'd6);
    check("i0_iter_cnt", 32'(iter_cnt), 32'd0);

    // iter = 5 with two stalled RUN cycles
    run_seq(5, 4, 2, -1, -1, -1, -1, 16, nd, lf, ll, ba);
    check("st_done_lat", 32'(lf), 32'd13);
    check("st_iter_cnt", 32'(iter_cnt), 32'd5);
`ifdef FU_SEQ_STALL_CNT_EN
    check("st_stall_cnt", 32'(stall_cnt), 32'd2);
`endif

    // abort in the 2nd RUN cycle
    run_seq(10, -1, 0, 3, -1, -1, -1, 8, nd, lf, ll, ba);
    check("ab_ndone", 32'(nd), 32'd0);
    check("ab_iter_cnt", 32'(iter_cnt), 32'd1);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_disable", 32'(fu_disable), 32'd1);

    // abort together with start in IDLE
    run_seq(7, -1, 0, 0, -1, -1, -1, 4, nd, lf, ll, ba);
    check("as_ndone", 32'(nd), 32'd0);
    check("as_busy", 32'(busy), 32'd0);
    check("as_iter_cnt_hold", 32'(iter_cnt), 32'd1);

    // reset during DRAIN
    iter = CNT_W'(3); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rd_busy", 32'(busy), 32'd0);
    check("rd_disable", 32'(fu_disable), 32'd1);
    check("rd_done", 32'(done), 32'd0);
    check("rd_iter_cnt", 32'(iter_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst   = ($urandom % 400) == 0;
      start = ($urandom % 3) == 0;
      iter  = CNT_W'($urandom_range(0, 12));
      stall = ($urandom % 4) == 0;
      abort = ($urandom % 50) == 0;
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
